// File: rtl/lieat_trap_pkg.sv
// Shared constants and state encoding for the commit-stage trap/return sequencer.
package lieat_trap_pkg;

    localparam int unsigned XLEN = 32;

    localparam logic [11:0] CsrNone    = 12'h000;
    localparam logic [11:0] CsrMstatus = 12'h300;
    localparam logic [11:0] CsrMtvec   = 12'h305;
    localparam logic [11:0] CsrMepc    = 12'h341;
    localparam logic [11:0] CsrMcause  = 12'h342;

    localparam logic [3:0] CauseIllegal = 4'd2;
    localparam logic [3:0] CauseBreak   = 4'd3;
    localparam logic [3:0] CauseEcallM  = 4'd11;

    localparam int unsigned MstatusMie   = 3;
    localparam int unsigned MstatusMpie  = 7;
    localparam int unsigned MstatusMppLo = 11;
    localparam int unsigned MstatusMppHi = 12;

    typedef enum logic [2:0] {
        StIdle   = 3'd0,
        StTRd    = 3'd1,
        StTWe    = 3'd2,
        StTWs    = 3'd3,
        StRedirT = 3'd4,
        StRRd    = 3'd5,
        StRWs    = 3'd6,
        StRedirR = 3'd7
    } trap_st_e;

endpackage

// File: rtl/lieat_general_dfflr.sv
// Generic load-enabled flop with asynchronous active-low reset to zero.
module lieat_general_dfflr #(
    parameter int unsigned DW = 32
) (
    input  logic          i_clk,
    input  logic          i_rstn,
    input  logic          i_lden,
    input  logic [DW-1:0] i_dnxt,
    output logic [DW-1:0] o_qout
);

    logic [DW-1:0] r_q;

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            r_q <= '0;
        end else if (i_lden) begin
            r_q <= i_dnxt;
        end
    end

    assign o_qout = r_q;

endmodule

// File: rtl/lieat_trap_mstatus_upd.sv
// Combinational mstatus next-values for trap entry and for mret.
module lieat_trap_mstatus_upd
    import lieat_trap_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic [XLEN-1:0] i_ms,
    output logic [XLEN-1:0] o_ms_trap,
    output logic [XLEN-1:0] o_ms_mret
);

    always_comb begin
        o_ms_trap = i_ms;
        o_ms_trap[MstatusMpie] = i_ms[MstatusMie];
        o_ms_trap[MstatusMie]  = 1'b0;
        o_ms_trap[MstatusMppHi:MstatusMppLo] = 2'b11;

        o_ms_mret = i_ms;
        o_ms_mret[MstatusMie]  = i_ms[MstatusMpie];
        o_ms_mret[MstatusMpie] = 1'b1;
        o_ms_mret[MstatusMppHi:MstatusMppLo] = 2'b11;
    end

endmodule

// File: rtl/lieat_exu_com_trapctrl.sv
// Commit-stage trap/mret sequencer: drives CSR commit/IFU-read ports and the front-end redirect.
module lieat_exu_com_trapctrl
    import lieat_trap_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic            i_clk,
    input  logic            i_rstn,
    input  logic            i_cmt_valid,
    output logic            o_cmt_ready,
    input  logic            i_cmt_ecall,
    input  logic            i_cmt_ebreak,
    input  logic            i_cmt_illegal,
    input  logic            i_cmt_mret,
    input  logic [XLEN-1:0] i_cmt_pc,
    output logic            o_csr_ena,
    output logic            o_csr_write,
    output logic            o_csr_read,
    output logic [11:0]     o_csr_idx,
    output logic [XLEN-1:0] o_csr_wdata,
    output logic [11:0]     o_csr_idx2,
    output logic [XLEN-1:0] o_csr_wdata2,
    input  logic [XLEN-1:0] i_csr_rdata,
    output logic            o_ifu_csr_ren,
    output logic [11:0]     o_ifu_csr_idx,
    input  logic [XLEN-1:0] i_ifu_csr_rdata,
    output logic            o_flush_req,
    output logic [XLEN-1:0] o_flush_pc,
    input  logic            i_flush_ack,
    output logic            o_trap_busy
);

    trap_st_e        r_st;
    trap_st_e        w_st_nxt;
    logic [2:0]      w_st_raw;
    logic [XLEN-1:0] r_epc;
    logic [3:0]      r_cause;
    logic [XLEN-1:0] r_ms;
    logic [3:0]      w_cause_nxt;
    logic            w_exc;
    logic            w_exc_acc;
    logic            w_ms_lden;
    logic [XLEN-1:0] w_ms_trap;
    logic [XLEN-1:0] w_ms_mret;
    logic            w_unused;

    assign w_exc       = i_cmt_illegal | i_cmt_ebreak | i_cmt_ecall;
    assign w_exc_acc   = i_cmt_valid & o_cmt_ready & w_exc;
    assign w_ms_lden   = (r_st == StTRd) | (r_st == StRRd);
    assign w_cause_nxt = i_cmt_illegal ? CauseIllegal :
                         i_cmt_ebreak  ? CauseBreak   : CauseEcallM;

    lieat_general_dfflr #(.DW(3)) u_st (
        .i_clk  (i_clk),
        .i_rstn (i_rstn),
        .i_lden (1'b1),
        .i_dnxt (w_st_nxt),
        .o_qout (w_st_raw)
    );
    assign r_st = trap_st_e'(w_st_raw);

    lieat_general_dfflr #(.DW(XLEN)) u_epc (
        .i_clk  (i_clk),
        .i_rstn (i_rstn),
        .i_lden (w_exc_acc),
        .i_dnxt (i_cmt_pc),
        .o_qout (r_epc)
    );

    lieat_general_dfflr #(.DW(4)) u_cause (
        .i_clk  (i_clk),
        .i_rstn (i_rstn),
        .i_lden (w_exc_acc),
        .i_dnxt (w_cause_nxt),
        .o_qout (r_cause)
    );

    lieat_general_dfflr #(.DW(XLEN)) u_ms (
        .i_clk  (i_clk),
        .i_rstn (i_rstn),
        .i_lden (w_ms_lden),
        .i_dnxt (i_csr_rdata),
        .o_qout (r_ms)
    );

    lieat_trap_mstatus_upd #(.XLEN(XLEN)) u_ms_upd (
        .i_ms      (r_ms),
        .o_ms_trap (w_ms_trap),
        .o_ms_mret (w_ms_mret)
    );

    assign o_cmt_ready = (r_st == StIdle);
    assign o_trap_busy = ~o_cmt_ready;

    always_comb begin
        w_st_nxt      = r_st;
        o_csr_ena     = 1'b0;
        o_csr_write   = 1'b0;
        o_csr_read    = 1'b0;
        o_csr_idx     = CsrNone;
        o_csr_wdata   = '0;
        o_csr_idx2    = CsrNone;
        o_csr_wdata2  = '0;
        o_ifu_csr_ren = 1'b0;
        o_ifu_csr_idx = CsrNone;
        o_flush_req   = 1'b0;
        o_flush_pc    = '0;
        unique case (r_st)
            StIdle: begin
                // A valid commit with no flag is consumed without any action.
                if (i_cmt_valid) begin
                    if (w_exc) begin
                        w_st_nxt = StTRd;
                    end else if (i_cmt_mret) begin
                        w_st_nxt = StRRd;
                    end
                end
            end
            StTRd: begin
                o_csr_ena  = 1'b1;
                o_csr_read = 1'b1;
                o_csr_idx  = CsrMstatus;
                w_st_nxt   = StTWe;
            end
            StTWe: begin
                o_csr_ena    = 1'b1;
                o_csr_write  = 1'b1;
                o_csr_idx    = CsrMepc;
                o_csr_wdata  = {r_epc[XLEN-1:1], 1'b0};
                o_csr_idx2   = CsrMcause;
                o_csr_wdata2 = {{(XLEN-4){1'b0}}, r_cause};
                w_st_nxt     = StTWs;
            end
            StTWs: begin
                o_csr_ena   = 1'b1;
                o_csr_write = 1'b1;
                o_csr_idx   = CsrMstatus;
                o_csr_wdata = w_ms_trap;
                w_st_nxt    = StRedirT;
            end
            StRedirT: begin
                o_ifu_csr_ren = 1'b1;
                o_ifu_csr_idx = CsrMtvec;
                o_flush_req   = 1'b1;
                o_flush_pc    = {i_ifu_csr_rdata[XLEN-1:2], 2'b00};
                if (i_flush_ack) begin
                    w_st_nxt = StIdle;
                end
            end
            StRRd: begin
                o_csr_ena  = 1'b1;
                o_csr_read = 1'b1;
                o_csr_idx  = CsrMstatus;
                w_st_nxt   = StRWs;
            end
            StRWs: begin
                o_csr_ena   = 1'b1;
                o_csr_write = 1'b1;
                o_csr_idx   = CsrMstatus;
                o_csr_wdata = w_ms_mret;
                w_st_nxt    = StRedirR;
            end
            StRedirR: begin
                o_ifu_csr_ren = 1'b1;
                o_ifu_csr_idx = CsrMepc;
                o_flush_req   = 1'b1;
                o_flush_pc    = {i_ifu_csr_rdata[XLEN-1:1], 1'b0};
                if (i_flush_ack) begin
                    w_st_nxt = StIdle;
                end
            end
            default: begin
                w_st_nxt = StIdle;
            end
        endcase
    end

    // Alignment bits are intentionally dropped from the saved PC and redirect target.
    assign w_unused = ^{r_epc[0], i_ifu_csr_rdata[0]};

endmodule

// File: tb/tb_lieat_exu_com_trapctrl.sv
// Directed self-checking bench for the trap/mret sequencer with a small CSR file model.
module tb_lieat_exu_com_trapctrl;

    localparam int unsigned XLEN = 32;

    logic            clk = 1'b0;
    logic            rstn = 1'b0;
    logic            cmt_valid = 1'b0;
    logic            cmt_ready;
    logic            cmt_ecall = 1'b0;
    logic            cmt_ebreak = 1'b0;
    logic            cmt_illegal = 1'b0;
    logic            cmt_mret = 1'b0;
    logic [XLEN-1:0] cmt_pc = '0;
    logic            csr_ena;
    logic            csr_write;
    logic            csr_read;
    logic [11:0]     csr_idx;
    logic [XLEN-1:0] csr_wdata;
    logic [11:0]     csr_idx2;
    logic [XLEN-1:0] csr_wdata2;
    logic [XLEN-1:0] csr_rdata;
    logic            ifu_csr_ren;
    logic [11:0]     ifu_csr_idx;
    logic [XLEN-1:0] ifu_csr_rdata;
    logic            flush_req;
    logic [XLEN-1:0] flush_pc;
    logic            flush_ack = 1'b0;
    logic            trap_busy;

    // CSR file model
    logic [31:0] m_mstatus = '0;
    logic [31:0] m_mtvec   = '0;
    logic [31:0] m_mepc    = '0;
    logic [31:0] m_mcause  = '0;
    int          wr_cnt    = 0;
    logic        bd_we     = 1'b0;
    logic [11:0] bd_idx    = '0;
    logic [31:0] bd_val    = '0;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    lieat_exu_com_trapctrl #(.XLEN(XLEN)) dut (
        .i_clk           (clk),
        .i_rstn          (rstn),
        .i_cmt_valid     (cmt_valid),
        .o_cmt_ready     (cmt_ready),
        .i_cmt_ecall     (cmt_ecall),
        .i_cmt_ebreak    (cmt_ebreak),
        .i_cmt_illegal   (cmt_illegal),
        .i_cmt_mret      (cmt_mret),
        .i_cmt_pc        (cmt_pc),
        .o_csr_ena       (csr_ena),
        .o_csr_write     (csr_write),
        .o_csr_read      (csr_read),
        .o_csr_idx       (csr_idx),
        .o_csr_wdata     (csr_wdata),
        .o_csr_idx2      (csr_idx2),
        .o_csr_wdata2    (csr_wdata2),
        .i_csr_rdata     (csr_rdata),
        .o_ifu_csr_ren   (ifu_csr_ren),
        .o_ifu_csr_idx   (ifu_csr_idx),
        .i_ifu_csr_rdata (ifu_csr_rdata),
        .o_flush_req     (flush_req),
        .o_flush_pc      (flush_pc),
        .i_flush_ack     (flush_ack),
        .o_trap_busy     (trap_busy)
    );

    always_comb begin
        case (csr_idx)
            12'h300: csr_rdata = m_mstatus;
            12'h305: csr_rdata = m_mtvec;
            12'h341: csr_rdata = m_mepc;
            12'h342: csr_rdata = m_mcause;
            default: csr_rdata = '0;
        endcase
        case (ifu_csr_idx)
            12'h305: ifu_csr_rdata = m_mtvec;
            12'h341: ifu_csr_rdata = m_mepc;
            default: ifu_csr_rdata = '0;
        endcase
    end

    always @(posedge clk) begin
        if (bd_we) begin
            case (bd_idx)
                12'h300: m_mstatus <= bd_val;
                12'h305: m_mtvec   <= bd_val;
                12'h341: m_mepc    <= bd_val;
                12'h342: m_mcause  <= bd_val;
                default: ;
            endcase
        end
        if (csr_ena && csr_write) begin
            wr_cnt <= wr_cnt + 1;
            case (csr_idx)
                12'h300: m_mstatus <= csr_wdata;
                12'h305: m_mtvec   <= csr_wdata;
                12'h341: m_mepc    <= csr_wdata;
                12'h342: m_mcause  <= csr_wdata;
                default: ;
            endcase
            case (csr_idx2)
                12'h300: m_mstatus <= csr_wdata2;
                12'h305: m_mtvec   <= csr_wdata2;
                12'h341: m_mepc    <= csr_wdata2;
                12'h342: m_mcause  <= csr_wdata2;
                default: ;
            endcase
        end
    end

    task automatic preset(input logic [11:0] idx, input logic [31:0] val);
        @(negedge clk);
        bd_we  = 1'b1;
        bd_idx = idx;
        bd_val = val;
        @(posedge clk);
        #1;
        bd_we = 1'b0;
    endtask

    // flags = {illegal, ebreak, ecall, mret}; returns just after the accepting edge
    task automatic issue(input logic [3:0] flags, input logic [31:0] pc);
        @(negedge clk);
        cmt_valid   = 1'b1;
        cmt_illegal = flags[3];
        cmt_ebreak  = flags[2];
        cmt_ecall   = flags[1];
        cmt_mret    = flags[0];
        cmt_pc      = pc;
        @(posedge clk);
        #1;
        cmt_valid   = 1'b0;
        cmt_illegal = 1'b0;
        cmt_ebreak  = 1'b0;
        cmt_ecall   = 1'b0;
        cmt_mret    = 1'b0;
    endtask

    // Counts edges after accept until flush_req is seen; also reports whether ready stayed low.
    task automatic wait_flush(output int n, output logic busy_all);
        n = 0;
        busy_all = 1'b1;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (cmt_ready !== 1'b0 || trap_busy !== 1'b1) busy_all = 1'b0;
            if (flush_req === 1'b1) return;
            n++;
        end
        n_cmp++;
        n_err++;
        $display("FAIL flush_timeout: got no flush_req, want one within 20 cycles");
    endtask

    task automatic do_ack;
        @(negedge clk);
        flush_ack = 1'b1;
        @(posedge clk);
        #1;
        flush_ack = 1'b0;
    endtask

    task automatic test_reset;
        rstn = 1'b0;
        @(negedge clk);
        n_cmp++;
        if ({cmt_ready, trap_busy, csr_ena, csr_read, csr_write, ifu_csr_ren, flush_req}
            !== 7'b1000000) begin
            n_err++;
            $display("FAIL reset_ctrl: got %b, want 1000000",
                     {cmt_ready, trap_busy, csr_ena, csr_read, csr_write, ifu_csr_ren, flush_req});
        end
        n_cmp++;
        if ({csr_idx, csr_idx2, ifu_csr_idx, csr_wdata, csr_wdata2, flush_pc} !== '0) begin
            n_err++;
            $display("FAIL reset_data: got idx=%h idx2=%h flush_pc=%h, want all zero",
                     csr_idx, csr_idx2, flush_pc);
        end
        @(negedge clk);
        rstn = 1'b1;
    endtask

    task automatic test_ecall;
        int n;
        logic busy;
        int w0;
        preset(12'h300, 32'h0000_0008);
        preset(12'h305, 32'h8000_0001);
        preset(12'h341, 32'h0);
        preset(12'h342, 32'h0);
        w0 = wr_cnt;
        issue(4'b0010, 32'h8000_0104);
        wait_flush(n, busy);
        n_cmp++;
        if (n !== 3) begin n_err++; $display("FAIL ecall_latency: got %0d, want 3", n); end
        n_cmp++;
        if (flush_pc !== 32'h8000_0000) begin
            n_err++; $display("FAIL ecall_flush_pc: got %h, want 80000000", flush_pc);
        end
        n_cmp++;
        if (ifu_csr_ren !== 1'b1 || ifu_csr_idx !== 12'h305) begin
            n_err++; $display("FAIL ecall_ifu_idx: got %b/%h, want 1/305", ifu_csr_ren, ifu_csr_idx);
        end
        do_ack();
        @(negedge clk);
        n_cmp++;
        if (cmt_ready !== 1'b1) begin n_err++; $display("FAIL ecall_idle: got %b, want 1", cmt_ready); end
        n_cmp++;
        if (m_mepc !== 32'h8000_0104) begin
            n_err++; $display("FAIL ecall_mepc: got %h, want 80000104", m_mepc);
        end
        n_cmp++;
        if (m_mcause !== 32'd11) begin n_err++; $display("FAIL ecall_mcause: got %h, want b", m_mcause); end
        n_cmp++;
        if (m_mstatus !== 32'h0000_1880) begin
            n_err++; $display("FAIL ecall_mstatus: got %h, want 00001880", m_mstatus);
        end
        n_cmp++;
        if (wr_cnt - w0 !== 2) begin
            n_err++; $display("FAIL ecall_wr_count: got %0d, want 2", wr_cnt - w0);
        end
    endtask

    task automatic test_priority;
        int n;
        logic busy;
        preset(12'h300, 32'h0);
        issue(4'b1110, 32'h0000_0200);
        wait_flush(n, busy);
        @(negedge clk);
        n_cmp++;
        if (!busy || cmt_ready !== 1'b0) begin
            n_err++; $display("FAIL prio_ready_low: got ready=%b busy_all=%b, want 0/1", cmt_ready, busy);
        end
        do_ack();
        n_cmp++;
        if (m_mcause !== 32'd2) begin n_err++; $display("FAIL prio_mcause: got %h, want 2", m_mcause); end
        n_cmp++;
        if (m_mepc !== 32'h200 || m_mstatus !== 32'h1800) begin
            n_err++; $display("FAIL prio_mepc_ms: got %h/%h, want 200/1800", m_mepc, m_mstatus);
        end
    endtask

    // flush_ack raised early in R_RD must not shorten or skip the sequence
    task automatic test_mret;
        int w0;
        preset(12'h300, 32'h0000_1880);
        preset(12'h341, 32'h8000_0104);
        w0 = wr_cnt;
        issue(4'b0001, 32'h0000_0040);
        @(negedge clk);
        flush_ack = 1'b1;
        @(negedge clk);
        flush_ack = 1'b0;
        n_cmp++;
        if (flush_req !== 1'b0 || cmt_ready !== 1'b0 || csr_write !== 1'b1) begin
            n_err++;
            $display("FAIL mret_early_ack: got req=%b ready=%b wr=%b, want 0/0/1",
                     flush_req, cmt_ready, csr_write);
        end
        @(negedge clk);
        n_cmp++;
        if (flush_req !== 1'b1 || flush_pc !== 32'h8000_0104 || ifu_csr_idx !== 12'h341) begin
            n_err++;
            $display("FAIL mret_redirect: got req=%b pc=%h idx=%h, want 1/80000104/341",
                     flush_req, flush_pc, ifu_csr_idx);
        end
        do_ack();
        n_cmp++;
        if (m_mstatus !== 32'h0000_1888) begin
            n_err++; $display("FAIL mret_mstatus: got %h, want 00001888", m_mstatus);
        end
        n_cmp++;
        if (wr_cnt - w0 !== 1 || m_mepc !== 32'h8000_0104) begin
            n_err++; $display("FAIL mret_writes: got %0d/%h, want 1/80000104", wr_cnt - w0, m_mepc);
        end
    endtask

    task automatic test_ack_hold;
        int n;
        logic busy;
        int w0;
        logic stable;
        preset(12'h300, 32'h0000_0008);
        preset(12'h305, 32'h0000_4567);
        issue(4'b0010, 32'h0000_1000);
        wait_flush(n, busy);
        w0 = wr_cnt;
        stable = (flush_req === 1'b1) && (flush_pc === 32'h0000_4564);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            if (flush_req !== 1'b1 || flush_pc !== 32'h0000_4564) stable = 1'b0;
        end
        n_cmp++;
        if (!stable) begin
            n_err++; $display("FAIL hold_stable: got req=%b pc=%h, want 1/00004564", flush_req, flush_pc);
        end
        n_cmp++;
        if (wr_cnt - w0 !== 0) begin
            n_err++; $display("FAIL hold_no_writes: got %0d, want 0", wr_cnt - w0);
        end
        do_ack();
        @(negedge clk);
        n_cmp++;
        if (cmt_ready !== 1'b1 || flush_req !== 1'b0) begin
            n_err++; $display("FAIL hold_idle: got ready=%b req=%b, want 1/0", cmt_ready, flush_req);
        end
    endtask

    task automatic test_reset_mid;
        int n;
        logic busy;
        int w0;
        preset(12'h300, 32'h0000_0008);
        preset(12'h341, 32'h1111_0000);
        preset(12'h342, 32'h0000_0007);
        w0 = wr_cnt;
        issue(4'b0010, 32'h0000_2224);
        @(negedge clk);
        @(negedge clk);
        n_cmp++;
        if (csr_write !== 1'b1 || csr_idx !== 12'h341 || csr_idx2 !== 12'h342) begin
            n_err++; $display("FAIL mid_in_twe: got wr=%b idx=%h idx2=%h, want 1/341/342",
                              csr_write, csr_idx, csr_idx2);
        end
        rstn = 1'b0;
        #1;
        n_cmp++;
        if ({cmt_ready, trap_busy, csr_ena, csr_write, csr_read, flush_req} !== 6'b100000 ||
            csr_idx !== 12'h000) begin
            n_err++; $display("FAIL mid_async_reset: got ready=%b ena=%b idx=%h, want 1/0/000",
                              cmt_ready, csr_ena, csr_idx);
        end
        @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (wr_cnt !== w0 || m_mstatus !== 32'h8 || m_mepc !== 32'h1111_0000) begin
            n_err++; $display("FAIL mid_no_writes: got cnt=%0d ms=%h epc=%h, want %0d/8/11110000",
                              wr_cnt, m_mstatus, m_mepc, w0);
        end
        issue(4'b0010, 32'h0000_3330);
        wait_flush(n, busy);
        n_cmp++;
        if (n !== 3 || flush_pc !== 32'h0000_4564) begin
            n_err++; $display("FAIL mid_resume: got lat=%0d pc=%h, want 3/00004564", n, flush_pc);
        end
        do_ack();
        n_cmp++;
        if (m_mepc !== 32'h3330 || m_mstatus !== 32'h1880 || m_mcause !== 32'd11) begin
            n_err++; $display("FAIL mid_resume_csr: got %h/%h/%h, want 3330/1880/b",
                              m_mepc, m_mstatus, m_mcause);
        end
    endtask

    task automatic test_noflag;
        int w0;
        logic quiet;
        w0 = wr_cnt;
        quiet = 1'b1;
        @(negedge clk);
        cmt_valid = 1'b1;
        cmt_pc    = 32'h0000_5550;
        flush_ack = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            if (csr_ena !== 1'b0 || flush_req !== 1'b0 || cmt_ready !== 1'b1) quiet = 1'b0;
        end
        cmt_valid = 1'b0;
        flush_ack = 1'b0;
        n_cmp++;
        if (!quiet) begin
            n_err++; $display("FAIL noflag_quiet: got ena=%b req=%b ready=%b, want 0/0/1",
                              csr_ena, flush_req, cmt_ready);
        end
        n_cmp++;
        if (wr_cnt !== w0) begin n_err++; $display("FAIL noflag_writes: got %0d, want %0d", wr_cnt, w0); end
    endtask

    initial begin
        test_reset();
        test_ecall();
        test_priority();
        test_mret();
        test_ack_hold();
        test_reset_mid();
        test_noflag();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
